data_mem_responder: RTL

Multi-cycle data-memory responder on the responder side of the processor's load/store port (MemRead, MemWrite, address, write_data, read_data). It adds a valid/ready request handshake and a one-cycle response strobe. Each accepted request is served after a programmable number of wait states, which lets a non-single-cycle core be tested against realistic memory latency. Storage is a doubleword-organised RAM with alignment and range checking.

---
 rtl/data_mem_responder.sv | 124 ++++++++++++
 1 files changed

// File: rtl/data_mem_responder.sv
// Data-memory responder: valid/ready request handshake, programmable wait states,
// one-cycle response strobe, and a doubleword RAM with alignment/range checking.
module data_mem_responder #(
    parameter int DEPTH       = 256,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        MemRead,
    input  logic        MemWrite,
    input  logic [63:0] address,
    input  logic [63:0] write_data,
    output logic        resp_valid,
    output logic [63:0] read_data,
    output logic        resp_err,
    output logic        busy
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;

    localparam int         IDX_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [3:0] CNT_INIT = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

    logic [1:0]  r_state;
    logic [3:0]  r_cnt;
    logic [63:0] r_addr;
    logic [63:0] r_wdata;
    logic        r_rd;
    logic        r_wr;
    logic [63:0] r_read_data;
    logic        r_err;
    logic [63:0] r_mem [DEPTH];

    logic             w_accept;
    logic             w_exec;
    logic [63:0]      w_addr;
    logic [63:0]      w_wdata;
    logic             w_rd;
    logic             w_wr;
    logic             w_err;
    logic [IDX_W-1:0] w_idx;

    assign w_accept = (r_state == S_IDLE) && req_valid && (MemRead || MemWrite);

    // With zero wait states the access executes on the accept edge itself, so the
    // operands come straight from the ports instead of the latched copies.
    assign w_exec  = (w_accept && (WAIT_CYCLES == 0)) ||
                     ((r_state == S_WAIT) && (r_cnt == 4'd0));
    assign w_addr  = (r_state == S_IDLE) ? address    : r_addr;
    assign w_wdata = (r_state == S_IDLE) ? write_data : r_wdata;
    assign w_rd    = (r_state == S_IDLE) ? MemRead    : r_rd;
    assign w_wr    = (r_state == S_IDLE) ? MemWrite   : r_wr;

    assign w_err = (w_addr[2:0] != 3'd0) || (w_addr[63:3] >= 61'(DEPTH)) || (w_rd && w_wr);
    assign w_idx = w_addr[IDX_W+2:3];

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_cnt       <= 4'd0;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_rd        <= 1'b0;
            r_wr        <= 1'b0;
            r_read_data <= '0;
            r_err       <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_addr  <= address;
                        r_wdata <= write_data;
                        r_rd    <= MemRead;
                        r_wr    <= MemWrite;
                        if (WAIT_CYCLES == 0) begin
                            r_state <= S_RESP;
                        end else begin
                            r_state <= S_WAIT;
                            r_cnt   <= CNT_INIT;
                        end
                    end
                end
                S_WAIT: begin
                    if (r_cnt == 4'd0) begin
                        r_state <= S_RESP;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                S_RESP:  r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase

            // Errors never touch memory; a store leaves read_data as it was.
            if (w_exec) begin
                if (w_err) begin
                    r_err       <= 1'b1;
                    r_read_data <= '0;
                end else begin
                    r_err <= 1'b0;
                    if (w_wr) begin
                        r_mem[w_idx] <= w_wdata;
                    end else begin
                        r_read_data <= r_mem[w_idx];
                    end
                end
            end
        end
    end

    assign req_ready  = (r_state == S_IDLE);
    assign busy       = (r_state != S_IDLE);
    assign resp_valid = (r_state == S_RESP);
    assign read_data  = r_read_data;
    assign resp_err   = r_err;

endmodule
